// File: rtl/tree_inorder_reader_pkg.sv
// Shared definitions for the in-order tree reader: default sizes, the NIL
// child marker, the node record layout and the traversal FSM encoding.
package tree_inorder_reader_pkg;

  localparam int KEY_W_DEF = 4;  // key width (matches sw[3:0])
  localparam int IDX_W_DEF = 3;  // node index width
  localparam int NODES_DEF = 7;  // max node count = traversal stack depth

  // The all-ones index marks an absent child.
  localparam logic [IDX_W_DEF-1:0] NIL_DEF = '1;

  // One node of the store as the writer lays it out.
  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [IDX_W_DEF-1:0] left;
    logic [IDX_W_DEF-1:0] right;
  } node_t;

  // Traversal FSM states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_POP   = 3'd3,
    S_EMIT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/tree_inorder_reader_if.sv
// Bundle of the reader's control, node-memory read port and key stream.
// The master side is the surrounding system (controller, node store,
// consumer); the slave side is the reader itself.
interface tree_inorder_reader_if
  import tree_inorder_reader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int IDX_W = IDX_W_DEF
);
  // control
  logic             start;
  logic [IDX_W-1:0] root_idx;
  logic [IDX_W-1:0] node_count;
  logic             busy;
  logic             done;
  logic             err;
  // node memory read port (1-cycle latency)
  logic [IDX_W-1:0] node_addr;
  logic             node_rd;
  logic [KEY_W-1:0] node_key;
  logic [IDX_W-1:0] node_left;
  logic [IDX_W-1:0] node_right;
  // key stream
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             key_ready;

  modport master (
    output start, root_idx, node_count,
    output node_key, node_left, node_right,
    output key_ready,
    input  busy, done, err,
    input  node_addr, node_rd,
    input  key_out, key_valid
  );

  modport slave (
    input  start, root_idx, node_count,
    input  node_key, node_left, node_right,
    input  key_ready,
    output busy, done, err,
    output node_addr, node_rd,
    output key_out, key_valid
  );

endinterface

// File: rtl/tree_inorder_reader_stack.sv
// LIFO holding the pending {key, right child} pairs of the in-order walk.
// The top entry is visible combinationally on dout; push and pop are never
// requested together by the reader.
module tree_inorder_reader_stack #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] top_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign top_idx = cnt_q - CNT_W'(1);

  // Occupancy: cleared by reset or a new traversal, stepped by push/pop.
  // NOTE: state registers use non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= top_idx;
    end
  end

  // Entry storage, written at the current occupancy.
  // NOTE: the array is not reset; the occupancy counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[cnt_q[AW-1:0]] <= din;
    end
  end

  // Top-of-stack view, zero when empty.
  // NOTE: dout gets a default before the if so no latch is inferred.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem_q[top_idx[AW-1:0]];
    end
  end

endmodule

// File: rtl/tree_inorder_reader.sv
// In-order walker of the binary-search-tree node store. Reads nodes through
// a 1-cycle-latency port, keeps pending ancestors on a LIFO and streams keys
// in ascending order on a valid/ready interface. Overflow of the LIFO or
// more emitted keys than stored nodes flags a corrupt/cyclic tree in err.
module tree_inorder_reader
  import tree_inorder_reader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int NODES = NODES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  tree_inorder_reader_if.slave  bus
);

  localparam logic [IDX_W-1:0] NIL   = '1;
  localparam int               CNT_W = IDX_W + 1;  // one spare bit so a cycle cannot wrap

  state_t           state_q;
  logic [IDX_W-1:0] cur_q;
  logic [IDX_W-1:0] count_q;
  logic [CNT_W-1:0] emit_cnt_q;
  logic [IDX_W-1:0] node_addr_q;
  logic             node_rd_q;
  logic [KEY_W-1:0] key_out_q;
  logic             key_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic                   start_acc;
  logic                   stk_push;
  logic                   stk_pop;
  logic                   stk_empty;
  logic                   stk_full;
  logic [KEY_W+IDX_W-1:0] stk_din;
  logic [KEY_W+IDX_W-1:0] stk_dout;
  logic [KEY_W-1:0]       pop_key;
  logic [IDX_W-1:0]       pop_right;
  logic [CNT_W-1:0]       emit_next;

  assign start_acc = (state_q == S_IDLE) && bus.start;
  assign stk_push  = (state_q == S_LATCH) && !stk_full;
  assign stk_pop   = (state_q == S_POP) && !stk_empty;
  assign stk_din   = {bus.node_key, bus.node_right};
  assign {pop_key, pop_right} = stk_dout;
  assign emit_next = emit_cnt_q + CNT_W'(1);

  tree_inorder_reader_stack #(
    .DEPTH (NODES),
    .WIDTH (KEY_W + IDX_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (start_acc),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // Traversal FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      count_q     <= '0;
      emit_cnt_q  <= '0;
      node_addr_q <= '0;
      node_rd_q   <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      node_rd_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            count_q    <= bus.node_count;
            emit_cnt_q <= '0;
            err_q      <= 1'b0;
            cur_q      <= bus.root_idx;
            if (bus.root_idx == NIL || bus.node_count == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= S_FETCH;
              busy_q      <= 1'b1;
              node_addr_q <= bus.root_idx;
              node_rd_q   <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          state_q <= S_LATCH;
        end

        S_LATCH: begin
          if (stk_full) begin
            err_q   <= 1'b1;
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (bus.node_left != NIL) begin
            cur_q       <= bus.node_left;
            node_addr_q <= bus.node_left;
            node_rd_q   <= 1'b1;
            state_q     <= S_FETCH;
          end else begin
            cur_q   <= bus.node_left;
            state_q <= S_POP;
          end
        end

        S_POP: begin
          if (stk_empty) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            key_out_q   <= pop_key;
            key_valid_q <= 1'b1;
            cur_q       <= pop_right;
            state_q     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (bus.key_ready) begin
            key_valid_q <= 1'b0;
            emit_cnt_q  <= emit_next;
            if (emit_next > {1'b0, count_q}) begin
              err_q   <= 1'b1;
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (cur_q != NIL) begin
              node_addr_q <= cur_q;
              node_rd_q   <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              state_q <= S_POP;
            end
          end
        end

        S_FIN: begin
          key_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.node_addr = node_addr_q;
  assign bus.node_rd   = node_rd_q;
  assign bus.key_out   = key_out_q;
  assign bus.key_valid = key_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
